// File: rtl/prog_loader_if.sv
// prog_loader_if: start, byte-stream, out-of-band write and status signals of the program loader
interface prog_loader_if;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [15:0] oob_write_addr;
  logic [15:0] oob_write_data;
  logic        oob_mem_wen;
  logic        comp_rst;
  logic        busy;
  logic        done;
  logic        err;
  modport master (
    output start, in_valid, in_data,
    input  in_ready, oob_write_addr, oob_write_data, oob_mem_wen, comp_rst, busy, done, err
  );
  modport slave (
    input  start, in_valid, in_data,
    output in_ready, oob_write_addr, oob_write_data, oob_mem_wen, comp_rst, busy, done, err
  );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: parses a length-prefixed little-endian byte stream into 16-bit words and
// writes them to comp memory through an out-of-band port while holding comp in reset
module prog_loader #(
  parameter int MAX_WORDS      = 256,
  parameter int RELEASE_CYCLES = 2
) (
  input logic         clk,
  input logic         rst,
  prog_loader_if.slave bus
);
  localparam int RW = $clog2(RELEASE_CYCLES + 1);
  localparam logic [16:0] MAXW = 17'(MAX_WORDS);
  typedef enum logic [3:0] {
    IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, WRITE, RELEASE, DONE, ERR
  } state_t;
  state_t        state_q, state_d;
  logic [15:0]   idx_q, idx_d, n_q, n_d, addr_q, addr_d, data_q, data_d;
  logic [7:0]    lo_q, lo_d;
  logic [RW-1:0] rel_q, rel_d;
  logic          acc;
  assign acc = bus.in_valid && (state_q inside {LEN_LO, LEN_HI, DATA_LO, DATA_HI});
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      n_q     <= '0;
      lo_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rel_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      lo_q    <= lo_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rel_q   <= rel_d;
    end
  end
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    n_d     = n_q;
    lo_d    = lo_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rel_d   = rel_q;
    case (state_q)
      IDLE, DONE, ERR: if (bus.start) begin
        state_d = LEN_LO;
        idx_d   = '0;
        n_d     = '0;
      end
      LEN_LO: if (acc) begin
        lo_d    = bus.in_data;
        state_d = LEN_HI;
      end
      LEN_HI: if (acc) begin
        n_d     = {bus.in_data, lo_q};
        rel_d   = '0;
        state_d = (n_d == 16'd0) ? RELEASE : ({1'b0, n_d} > MAXW) ? ERR : DATA_LO;
      end
      DATA_LO: if (acc) begin
        lo_d    = bus.in_data;
        state_d = DATA_HI;
      end
      // address/data are captured here so they stay stable outside WRITE
      DATA_HI: if (acc) begin
        addr_d  = idx_q;
        data_d  = {bus.in_data, lo_q};
        state_d = WRITE;
      end
      WRITE: begin
        idx_d   = idx_q + 16'd1;
        rel_d   = '0;
        state_d = ({1'b0, idx_q} + 17'd1 < {1'b0, n_q}) ? DATA_LO : RELEASE;
      end
      RELEASE: begin
        rel_d   = rel_q + 1'b1;
        state_d = (rel_q == RW'(RELEASE_CYCLES - 1)) ? DONE : RELEASE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    bus.in_ready       = state_q inside {LEN_LO, LEN_HI, DATA_LO, DATA_HI};
    bus.oob_mem_wen    = state_q == WRITE;
    bus.oob_write_addr = addr_q;
    bus.oob_write_data = data_q;
    bus.busy           = !(state_q inside {IDLE, DONE, ERR});
    bus.done           = state_q == DONE;
    bus.err            = state_q == ERR;
    bus.comp_rst       = state_q != DONE;
  end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: table vectors, corner-case sequences and random loads checked
// against a stream-level model of the loader
module tb_prog_loader;
  localparam int MAXW = 256;
  localparam int RC   = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  prog_loader_if bus();
  prog_loader #(.MAX_WORDS(MAXW), .RELEASE_CYCLES(RC)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] obs[$];
  int rel_cnt = 0;
  int viol = 0;
  logic prev_wen = 1'b0;
  logic prev_rst = 1'b1;
  logic [15:0] prev_a = '0;
  logic [15:0] prev_d = '0;
  typedef struct {
    logic [7:0]  b[6];
    int          len;
    int          nw;
    logic [15:0] w0;
    logic [15:0] w1;
    logic        e;
  } vec_t;
  vec_t tbl[4];
  // observer: collects writes, counts release cycles, flags protocol breaches
  always @(negedge clk) begin
    if (bus.oob_mem_wen) begin
      obs.push_back({bus.oob_write_addr, bus.oob_write_data});
      if (prev_wen) viol++;
    end else if (!prev_rst && (bus.oob_write_addr !== prev_a || bus.oob_write_data !== prev_d)) viol++;
    if (bus.comp_rst !== !bus.done) viol++;
    if (bus.busy && !bus.in_ready && !bus.oob_mem_wen) rel_cnt++;
    prev_wen = bus.oob_mem_wen;
    prev_rst = rst;
    prev_a   = bus.oob_write_addr;
    prev_d   = bus.oob_write_data;
  end
  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [39:0] outs();
    return {2'b0, bus.in_ready, bus.oob_mem_wen, bus.comp_rst, bus.busy, bus.done, bus.err,
            bus.oob_write_addr, bus.oob_write_data};
  endfunction
  task automatic clear_obs();
    obs.delete();
    rel_cnt = 0;
    viol = 0;
  endtask
  task automatic pulse_start();
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask
  task automatic send_byte(input logic [7:0] b, output logic ok);
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    chk("byte_accept", {39'b0, ok}, 40'd1);
  endtask
  task automatic wait_end();
    logic fin = 1'b0;
    for (int t = 0; t < 100 && !fin; t++) begin
      @(negedge clk);
      if (bus.done || bus.err) fin = 1'b1;
    end
    chk("end_reached", {39'b0, fin}, 40'd1);
  endtask
  task automatic load(input logic [7:0] q[$], input int gap, input int poke);
    logic ok = 1'b1;
    clear_obs();
    pulse_start();
    for (int i = 0; i < q.size() && ok; i++) begin
      if (i == poke) pulse_start();
      repeat (gap == 2 ? $urandom_range(0, 2) : gap) @(posedge clk);
      #1;
      send_byte(q[i], ok);
    end
    wait_end();
  endtask
  // model: N words follow the length, low byte first; N > MAXW errors with no writes
  task automatic check_model(input logic [7:0] q[$]);
    int n = {q[1], q[0]};
    logic e = n > MAXW;
    int nw = e ? 0 : n;
    chk("err", {39'b0, bus.err}, {39'b0, e});
    chk("done", {39'b0, bus.done}, {39'b0, !e});
    chk("nwrites", 40'(obs.size()), 40'(nw));
    for (int i = 0; i < nw && i < obs.size(); i++)
      chk("write", {8'b0, obs[i]}, {8'b0, i[15:0], q[3 + 2 * i], q[2 + 2 * i]});
    chk("release_cycles", 40'(rel_cnt), 40'(e ? 0 : RC));
    chk("protocol", 40'(viol), 40'd0);
  endtask
  initial begin
    logic [7:0] q[$];
    logic ok;
    int n;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    tbl[0].b = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56};
    tbl[0].len = 6; tbl[0].nw = 2; tbl[0].w0 = 16'h1234; tbl[0].w1 = 16'h5678; tbl[0].e = 1'b0;
    tbl[1].b = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[1].len = 2; tbl[1].nw = 0; tbl[1].w0 = 16'h0; tbl[1].w1 = 16'h0; tbl[1].e = 1'b0;
    tbl[2].b = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[2].len = 2; tbl[2].nw = 0; tbl[2].w0 = 16'h0; tbl[2].w1 = 16'h0; tbl[2].e = 1'b1;
    tbl[3].b = '{8'h01, 8'h00, 8'hCD, 8'hAB, 8'h00, 8'h00};
    tbl[3].len = 4; tbl[3].nw = 1; tbl[3].w0 = 16'hABCD; tbl[3].w1 = 16'h0; tbl[3].e = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", outs(), {2'b0, 6'b001000, 32'h0});
    @(posedge clk); #1;
    rst = 1'b0;
    for (int g = 0; g < 2; g++)
      for (int k = 0; k < 4; k++) begin
        q.delete();
        for (int i = 0; i < tbl[k].len; i++) q.push_back(tbl[k].b[i]);
        load(q, g, -1);
        check_model(q);
        chk("tbl_nw", 40'(obs.size()), 40'(tbl[k].nw));
        chk("tbl_err", {39'b0, bus.err}, {39'b0, tbl[k].e});
        if (tbl[k].nw > 0 && obs.size() > 0) chk("tbl_w0", {24'b0, obs[0][15:0]}, {24'b0, tbl[k].w0});
        if (tbl[k].nw > 1 && obs.size() > 1) chk("tbl_w1", {24'b0, obs[1][15:0]}, {24'b0, tbl[k].w1});
      end
    q = '{8'h01, 8'h01};
    load(q, 0, -1);
    check_model(q);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h99;
    repeat (3) begin
      @(negedge clk);
      chk("err_hold", {36'b0, bus.in_ready, bus.err, bus.comp_rst, bus.busy}, 40'b0110);
    end
    bus.in_valid = 1'b0;
    pulse_start();
    @(negedge clk);
    chk("err_restart", {36'b0, bus.in_ready, bus.err, bus.busy, bus.comp_rst}, 40'b1011);
    clear_obs();
    @(posedge clk); #1;
    send_byte(8'h03, ok);
    send_byte(8'h00, ok);
    send_byte(8'hAA, ok);
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("abort_outputs", outs(), {2'b0, 6'b001000, 32'h0});
    chk("abort_nwrites", 40'(obs.size()), 40'd0);
    q = '{8'h00, 8'h01};
    for (int i = 0; i < 512; i++) q.push_back(8'($urandom));
    load(q, 0, -1);
    check_model(q);
    if (obs.size() > 0) chk("last_addr", {24'b0, obs[$][31:16]}, 40'd255);
    q = '{8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56};
    load(q, 0, 2);
    check_model(q);
    for (int r = 0; r < 12; r++) begin
      n = ($urandom_range(0, 4) == 0) ? $urandom_range(MAXW + 1, 600) : $urandom_range(0, 6);
      q = '{8'(n), 8'(n >> 8)};
      if (n <= MAXW) for (int i = 0; i < 2 * n; i++) q.push_back(8'($urandom));
      load(q, $urandom_range(0, 2), $urandom_range(0, 1) ? $urandom_range(0, q.size() - 1) : -1);
      check_model(q);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter MAX_WORDS, default 256: largest accepted program length, in 16-bit words.
REQ-002 Parameter RELEASE_CYCLES, default 2: cycles comp_rst stays high after the last memory write.
REQ-003 clk  input  1  single clock; all logic on posedge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle request to begin a load; sampled only in IDLE, DONE, ERR.
REQ-006 in_valid  input  1  byte-stream valid.
REQ-007 in_data  input  8  byte-stream data.
REQ-008 in_ready  output  1  byte accepted on a clk edge where in_valid && in_ready.
REQ-009 oob_write_addr  output  16  word address to the comp memory out-of-band write port.
REQ-010 oob_write_data  output  16  word data to the out-of-band write port.
REQ-011 oob_mem_wen  output  1  out-of-band write enable, one cycle per word.
REQ-012 comp_rst  output  1  reset to comp; high while loading.
REQ-013 busy  output  1  high in every state except IDLE, DONE, ERR.
REQ-014 done  output  1  level, high in DONE.
REQ-015 err  output  1  level, high in ERR.

Function
REQ-016 Stream format: 2-byte little-endian word count N, then N words, each low byte first, then high byte.
REQ-017 States: IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, WRITE, RELEASE, DONE, ERR.
REQ-018 in_ready = 1 only in LEN_LO, LEN_HI, DATA_LO, DATA_HI; each accepted byte advances the state by exactly one step; no acceptance when in_valid=0.
REQ-019 IDLE/DONE/ERR + start -> LEN_LO; word index and count cleared; comp_rst driven high from the next cycle.
REQ-020 LEN_HI accept: N == 0 -> RELEASE; N > MAX_WORDS -> ERR; else -> DATA_LO.
REQ-021 DATA_HI accept -> WRITE; in WRITE, oob_mem_wen=1 for exactly that one cycle, oob_write_addr = word index (0-based), oob_write_data = {high byte, low byte}.
REQ-022 WRITE -> DATA_LO if index+1 < N, else RELEASE; index increments by 1 per write; max write throughput one word per 3 cycles.
REQ-023 oob_write_addr/oob_write_data hold their last values when oob_mem_wen=0; oob_mem_wen=0 in every state except WRITE.
REQ-024 RELEASE lasts exactly RELEASE_CYCLES cycles with comp_rst=1, then -> DONE.
REQ-025 comp_rst = 0 only in DONE; 1 in all other states including IDLE and ERR.
REQ-026 ERR: no further bytes consumed; err=1 until rst or start.
REQ-027 start while busy is ignored.
REQ-028 Index never wraps; index == N always exits via RELEASE before the 17th address bit is needed.

Reset
REQ-029 rst=1 at a clk edge -> next cycle: state IDLE, in_ready=0, oob_mem_wen=0, oob_write_addr=0, oob_write_data=0, comp_rst=1, busy=0, done=0, err=0, index=0, N=0.
REQ-030 rst mid-load aborts immediately; partial writes already issued are not undone; a byte presented during the rst cycle is not accepted.
REQ-031 rst has priority over start and in_valid in the same cycle.

Verification
REQ-032 start; stream 02 00 34 12 78 56 with in_valid always 1 -> two writes (addr 0, data 1234) then (addr 1, data 5678); comp_rst high for 2 cycles after second write; then done=1, comp_rst=0.
REQ-033 Same stream with in_valid toggling every other cycle -> identical write sequence; no duplicate or dropped bytes.
REQ-034 start; stream 00 00 -> no oob_mem_wen pulse; RELEASE 2 cycles; done=1.
REQ-035 start; stream 01 01 (N=257) -> err=1, in_ready=0, comp_rst=1, no writes; then start -> LEN_LO, err=0.
REQ-036 rst asserted after the first data byte of a 3-word load -> IDLE next cycle, all outputs at reset values; a subsequent full load of 256 words writes addrs 0..255 in order, addr 255 last, then done.
REQ-037 start while in DATA_LO -> ignored; load completes normally.
